sm4_key_sched: RTL and testbench
================================

Name: sm4_key_sched

Overview:
- Sequencer for the SM4 key expansion. It drives one 32-bit tau datapath (four instances of the SM4 S-box) for 32 rounds.
- Expands a 128-bit master key into rk0..rk31 at one round per cycle.
- Streams each round key over a valid/ready interface and keeps all 32 keys in a local key store for random-access reads.
- Sits between the key-load register interface and the SM4 round-function engine. That engine reads keys in reverse order for decryption.

Parameters:
- ROUNDS, 32, number of round keys generated. Fixed at 32 for SM4; the counter is 5 bits wide.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  single-cycle request to expand key_in; ignored while busy=1
- key_in  input  128  master key MK, MK0 = key_in[127:96]; sampled only on an accepted start
- busy  output  1  high from the cycle after an accepted start until done
- rk_valid  output  1  rk_out/rk_idx hold a valid round key
- rk_ready  input  1  consumer accepts the key; the handshake is rk_valid&rk_ready
- rk_out  output  32  round key rk[rk_idx]
- rk_idx  output  5  round index 0..31
- done  output  1  one-cycle pulse the cycle after handshake of rk_idx=31
- keys_ok  output  1  key store holds a complete, consistent key set
- rd_addr  input  5  key store read index
- rd_data  output  32  registered key store read data, 1-cycle latency

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy, rk_valid, done and keys_ok go to 0.
  - rk_out, rk_idx and rd_data go to 0.
  - The FSM goes to IDLE; the round counter and K0..K3 go to 0.
  - Key store contents are not cleared.
  - A reset mid-expansion aborts it; keys_ok stays 0 until a later full expansion completes.
- Constants:
  - FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - CK_i byte j (j=0 is the MSB) = (28*i + 7*j) mod 256, computed arithmetically with no table.
- Round datapath, combinational, from registers K0..K3 and counter i:
  - X = K1^K2^K3^CK_i.
  - B = tau(X), the S-box applied to each byte.
  - rk = K0 ^ B ^ (B<<<13) ^ (B<<<23).
- IDLE:
  - On start=1: load K0..3 = MK0..3 ^ FK0..3, set i=0, clear keys_ok and go to RUN.
  - busy=1 from the next cycle.
- RUN, when slot free (rk_valid=0 or rk_ready=1):
  - Register rk_out=rk, rk_idx=i, rk_valid=1.
  - Write store[i]=rk.
  - Shift K0..K3 <= K1,K2,K3,rk and increment i.
  - After issuing i=31, go to DRAIN.
- RUN, slot blocked (rk_valid=1 and rk_ready=0): hold rk_out, rk_idx, K and i.
- DRAIN:
  - On handshake of index 31: rk_valid=0 and go to IDLE.
  - The next cycle: done=1, keys_ok=1, busy=0.
- Valid/ready rules:
  - rk_out and rk_idx are stable while rk_valid=1 and rk_ready=0.
  - rk_valid never drops without a handshake, except on reset.
  - Each index is issued exactly once, in order 0..31.
- Latency and throughput:
  - First rk_valid is 2 cycles after the start cycle.
  - With rk_ready tied high: 32 consecutive valid cycles, done 1 cycle after the last; 35 cycles from start to done.
- Simultaneous events and misuse:
  - start while busy is ignored and does not corrupt state.
  - start in the same cycle as the done pulse is accepted; done still pulses.
- Key store read port:
  - rd_data <= store[rd_addr] every cycle.
  - A read of the index being written in the same cycle returns the old value.
  - Contents are meaningful only when keys_ok=1.

Test Plan:
- key_in=0123456789ABCDEFFEDCBA9876543210, rk_ready=1, pulse start -> rk_valid at cycle +2; rk0=F12186F9, rk1=41662B61, rk31=9124A012; idx 0..31 contiguous; done at +35; keys_ok=1.
- Same key, rk_ready toggling pseudo-randomly -> identical key sequence, no index skipped or repeated; rk_out stable during every stall; done after the final handshake.
- After a completed expansion, read rd_addr 0..31 -> rd_data one cycle later equals the streamed rk sequence; rd_addr=31 returns 9124A012.
- start pulsed again at rk_idx=10 with key_in=0 -> ignored; sequence continues unchanged for the original key.
- rst_n=0 for one cycle at rk_idx=15 -> next cycle all outputs are 0 and keys_ok=0; a new start with key_in=0 then produces rk0 = expansion of the all-zero key, matching the golden model.
- CK check: instrument the round counter -> CK0=00070E15, CK1=1C232A31, CK31=646B7279.

Source files
------------

// File: rtl/sm4_key_sched_if.sv
// Stream-side bundle of the SM4 key scheduler: start/key request plus the round-key output.
// A key transfers on every rising edge where rk_valid && rk_ready. Once rk_valid is high,
// rk_out/rk_idx hold until that transfer occurs, and rk_valid drops only after a transfer or on reset.
interface sm4_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_out;
  logic [4:0]   rk_idx;
  logic         done;

  modport master (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );

  modport slave (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );
endinterface

// File: rtl/sm4_key_sched.sv
// SM4 key expansion sequencer: one round key per cycle through a shared tau datapath,
// streamed over valid/ready and mirrored into a 32-entry key store with a registered read port.
module sm4_key_sched (
  input  logic                   clk,
  input  logic                   rst_n,
  sm4_key_sched_if.master        stream,
  output logic                   keys_ok,
  input  logic [4:0]             rd_addr,
  output logic [31:0]            rd_data,
  output logic [1:0]             dbg_state
);
  localparam int ROUNDS = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] store [0:ROUNDS-1];

  logic [7:0]  ck_base;
  logic [31:0] ck;
  logic [31:0] x;
  logic [31:0] b;
  logic [31:0] rk;
  logic        slot_free;
  logic        issue;

  // CK bytes step by 7 within a word and by 28 per round, all modulo 256.
  always_comb begin
    ck_base = ({3'b000, cnt} << 4) + ({3'b000, cnt} << 3) + ({3'b000, cnt} << 2);
    ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
    x       = k1 ^ k2 ^ k3 ^ ck;
    b       = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    rk      = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  end

  assign slot_free = !stream.rk_valid || stream.rk_ready;
  assign issue     = (state == RUN) && slot_free;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 5'd0;
      k0              <= 32'd0;
      k1              <= 32'd0;
      k2              <= 32'd0;
      k3              <= 32'd0;
      stream.busy     <= 1'b0;
      stream.rk_valid <= 1'b0;
      stream.rk_out   <= 32'd0;
      stream.rk_idx   <= 5'd0;
      stream.done     <= 1'b0;
      keys_ok         <= 1'b0;
    end else begin
      stream.done <= 1'b0;
      case (state)
        IDLE: begin
          if (stream.start) begin
            k0          <= stream.key_in[127:96] ^ FK0;
            k1          <= stream.key_in[95:64]  ^ FK1;
            k2          <= stream.key_in[63:32]  ^ FK2;
            k3          <= stream.key_in[31:0]   ^ FK3;
            cnt         <= 5'd0;
            keys_ok     <= 1'b0;
            stream.busy <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (slot_free) begin
            stream.rk_out   <= rk;
            stream.rk_idx   <= cnt;
            stream.rk_valid <= 1'b1;
            k0              <= k1;
            k1              <= k2;
            k2              <= k3;
            k3              <= rk;
            cnt             <= cnt + 5'd1;
            if (cnt == 5'(ROUNDS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (stream.rk_valid && stream.rk_ready) begin
            stream.rk_valid <= 1'b0;
            state           <= FINISH;
          end
        end
        default: begin
          // Completion is reported one cycle after the final transfer.
          stream.done <= 1'b1;
          stream.busy <= 1'b0;
          keys_ok     <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Key store survives reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && issue) store[cnt] <= rk;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= 32'd0;
    else        rd_data <= store[rd_addr];
  end
endmodule

// File: tb/tb_sm4_key_sched.sv
// Self-checking bench for sm4_key_sched: random keys and backpressure against an
// array-based SM4 key expansion model, plus reset, misuse and key-store read checks.
module tb_sm4_key_sched;
  localparam logic [127:0] GOLD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic        clk;
  logic        rst_n;
  logic        keys_ok;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  dbg_state;

  sm4_key_sched_if kif ();

  sm4_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream    (kif.master),
    .keys_ok   (keys_ok),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rk [32];
  logic [31:0] streamed [32];
  int  hs_count, done_cnt, first_cyc, done_cyc, start_cyc;
  bit  mon_en, first_seen, prev_stall, rand_ready;
  logic [31:0] prev_out;
  logic [4:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model, written straight from the SM4 key expansion rules
  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w = 0;
    for (int j = 0; j < 4; j++) w = (w << 8) | 32'((28 * i + 7 * j) % 256);
    return w;
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] v);
    logic [31:0] s = 0;
    for (int j = 3; j >= 0; j--) s = (s << 8) | 32'(SBOX[v[8*j +: 8]]);
    return s ^ ((s << 13) | (s >> 19)) ^ ((s << 23) | (s >> 9));
  endfunction

  task automatic model_expand(input logic [127:0] mk);
    logic [31:0] fk [4];
    logic [31:0] k [36];
    fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
    for (int j = 0; j < 4; j++) k[j] = mk[127 - 32*j -: 32] ^ fk[j];
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
      model_rk[i] = k[i+4];
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (kif.rk_valid && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
      end
      if (kif.rk_valid && prev_stall) begin
        check("stall_out", kif.rk_out, prev_out);
        check("stall_idx", 32'(kif.rk_idx), 32'(prev_idx));
      end
      if (kif.rk_valid && kif.rk_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_key_idx", 32'(kif.rk_idx), 32'hFFFFFFFF);
        end else begin
          check("rk_out", kif.rk_out, exp_q.pop_front());
          check("rk_idx", 32'(kif.rk_idx), 32'(hs_count));
          streamed[hs_count] = kif.rk_out;
          hs_count++;
        end
      end
      prev_stall = kif.rk_valid && !kif.rk_ready;
      prev_out   = kif.rk_out;
      prev_idx   = kif.rk_idx;
      if (kif.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dbg_state == 2'd1) begin
        if (dut.cnt == 5'd0)  check("ck0",  dut.ck, 32'h00070E15);
        if (dut.cnt == 5'd1)  check("ck1",  dut.ck, 32'h1C232A31);
        if (dut.cnt == 5'd31) check("ck31", dut.ck, 32'h646B7279);
      end
    end
  end

  // driver: consumer backpressure
  initial begin
    kif.rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      kif.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver tasks
  task automatic begin_expansion(input logic [127:0] key, input bit rr);
    model_expand(key);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(model_rk[i]);
    hs_count = 0; done_cnt = 0; first_seen = 0; prev_stall = 0;
    rand_ready = rr;
    mon_en = 1;
    @(posedge clk); #1;
    kif.start  = 1'b1;
    kif.key_in = key;
    start_cyc  = cyc;
    @(posedge clk); #1;
    kif.start  = 1'b0;
    kif.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_hs(input int n, input int budget);
    int w = 0;
    while (hs_count < n && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    if (hs_count < n) check("hs_timeout", 32'(hs_count), 32'(n));
  endtask

  task automatic finish_expansion(input string tag, input bit timed, input int budget);
    int w = 0;
    while (done_cnt == 0 && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    check({tag, "_hs_count"}, 32'(hs_count), 32'd32);
    check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_keys_ok"}, 32'(keys_ok), 32'd1);
    check({tag, "_busy_low"}, 32'(kif.busy), 32'd0);
    check({tag, "_first_lat"}, 32'(first_cyc - start_cyc), 32'd2);
    if (timed) check({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'd35);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    mon_en = 0;
  endtask

  task automatic check_store(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      @(posedge clk); #1;
      check({tag, "_rd"}, rd_data, model_rk[a]);
      check({tag, "_rd_vs_stream"}, rd_data, streamed[a]);
    end
  endtask

  initial begin
    mon_en = 0; rand_ready = 0;
    kif.start = 1'b0; kif.key_in = '0; rd_addr = 5'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(kif.busy), 32'd0);
    check("rst_valid", 32'(kif.rk_valid), 32'd0);
    check("rst_done", 32'(kif.done), 32'd0);
    check("rst_keys_ok", 32'(keys_ok), 32'd0);
    check("rst_rk_out", kif.rk_out, 32'd0);
    check("rst_rk_idx", 32'(kif.rk_idx), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // golden key, no backpressure
    begin_expansion(GOLD_KEY, 0);
    finish_expansion("gold", 1, 200);
    check("gold_rk0", streamed[0], 32'hF12186F9);
    check("gold_rk1", streamed[1], 32'h41662B61);
    check("gold_rk31", streamed[31], 32'h9124A012);
    check_store("gold");
    rd_addr = 5'd31;
    @(posedge clk); #1;
    check("rd31_gold", rd_data, 32'h9124A012);

    // golden key, random backpressure
    begin_expansion(GOLD_KEY, 1);
    finish_expansion("gold_bp", 0, 600);

    // start while busy must be ignored
    begin_expansion(GOLD_KEY, 0);
    wait_hs(10, 100);
    kif.start = 1'b1; kif.key_in = '0;
    @(posedge clk); #1;
    kif.start = 1'b0;
    finish_expansion("busy_start", 1, 200);

    // reset mid-expansion, then expand the all-zero key
    begin_expansion(GOLD_KEY, 0);
    wait_hs(15, 100);
    @(posedge clk); #1;
    mon_en = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(kif.busy), 32'd0);
    check("mid_rst_valid", 32'(kif.rk_valid), 32'd0);
    check("mid_rst_done", 32'(kif.done), 32'd0);
    check("mid_rst_keys_ok", 32'(keys_ok), 32'd0);
    check("mid_rst_rk_out", kif.rk_out, 32'd0);
    check("mid_rst_rk_idx", 32'(kif.rk_idx), 32'd0);
    check("mid_rst_rd_data", rd_data, 32'd0);
    begin_expansion(128'd0, 0);
    finish_expansion("zero_key", 1, 200);

    // random keys with random backpressure
    for (int n = 0; n < 4; n++) begin
      begin_expansion({$urandom(), $urandom(), $urandom(), $urandom()}, 1);
      finish_expansion("rand", 0, 600);
    end
    check_store("rand");

    // start in the same cycle as done is accepted
    begin_expansion(GOLD_KEY, 0);
    while (done_cnt == 0 && cyc < start_cyc + 60) begin
      @(negedge clk);
    end
    check("b2b_done_pulse", 32'(done_cnt), 32'd1);
    mon_en = 0;
    #4;
    kif.start = 1'b1; kif.key_in = 128'd0;
    @(posedge clk); #1;
    kif.start = 1'b0;
    check("b2b_busy", 32'(kif.busy), 32'd1);
    check("b2b_keys_ok_clr", 32'(keys_ok), 32'd0);
    model_expand(128'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(model_rk[i]);
    hs_count = 0; done_cnt = 0; first_seen = 0; prev_stall = 0;
    start_cyc = cyc - 1;
    mon_en = 1;
    finish_expansion("b2b", 1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
